// File: rtl/rr_grant_seq8_if.sv
// Arbiter request/grant bundle: the requester vector going in, and the
// decoder3e-ready index/enable plus a busy status coming back.
interface rr_grant_seq8_if;
  logic [7:0] req;
  logic [2:0] n;
  logic       ena;
  logic       busy;

  // Requester side drives req and observes the grant.
  modport master (output req, input n, ena, busy);

  // Arbiter side consumes req and produces the grant.
  modport slave (input req, output n, ena, busy);
endinterface

// File: rtl/rr_grant_seq8.sv
// 8-way round-robin arbiter feeding decoder3e (index n + enable ena).
// All outputs are registered, so there is no combinational path from req.
// Fairness comes from a rotating last-served pointer. A grant held while
// others wait is pre-empted after MAX_HOLD cycles (0 disables pre-emption).
module rr_grant_seq8 #(
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           clrn,
  rr_grant_seq8_if.slave arb
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [2:0] n_q, n_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;

  logic       hit;
  logic [2:0] hit_idx;
  logic [2:0] search_base;
  logic [7:0] others;
  logic       hold_expired;

  // First requester strictly after p, wrapping round to p itself last.
  function automatic logic [3:0] search(input logic [2:0] p, input logic [7:0] r);
    logic       found;
    logic [2:0] idx;
    logic [2:0] cand;
    found = 1'b0;
    idx   = p;
    for (int k = 1; k <= 8; k++) begin
      cand = p + 3'(k);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // Search from the last-served index when idle, from the current holder when granting.
  always_comb begin
    search_base       = (state_q == GRANT) ? n_q : ptr_q;
    {hit, hit_idx}    = search(search_base, arb.req);
    others            = arb.req & ~(8'b1 << n_q);
    hold_expired      = (MAX_HOLD_C != 8'd0) && (cnt_q >= MAX_HOLD_C);
  end

  // Next-state logic: start, release/handover, pre-empt, or keep holding.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb.req != 8'd0) begin
          n_d     = hit_idx;
          cnt_d   = 8'd1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!arb.req[n_q]) begin
          ptr_d = n_q;
          if (hit) begin
            n_d   = hit_idx;
            cnt_d = 8'd1;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_expired && (others != 8'd0)) begin
          ptr_d = n_q;
          n_d   = hit_idx;
          cnt_d = 8'd1;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset restarts arbitration from index 0 (ptr = 7).
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      n_q     <= 3'd0;
      ptr_q   <= 3'd7;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign arb.n    = n_q;
  assign arb.ena  = (state_q == GRANT);
  assign arb.busy = (state_q == GRANT);

endmodule

// File: tb/tb_rr_grant_seq8.sv
// Directed bench for rr_grant_seq8. A local decoder3e model turns n/ena into
// the one-hot e vector so the grant can be checked as the consumer sees it.
module tb_rr_grant_seq8;

  logic clk;
  logic clrn;
  int   checks;
  int   errors;
  int   idx_count [8];

  rr_grant_seq8_if m_if ();
  rr_grant_seq8_if f_if ();

  rr_grant_seq8 #(.MAX_HOLD(4)) u_dut (
    .clk  (clk),
    .clrn (clrn),
    .arb  (m_if.slave)
  );

  rr_grant_seq8 #(.MAX_HOLD(1)) u_dut_fair (
    .clk  (clk),
    .clrn (clrn),
    .arb  (f_if.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] decode3e(input logic [2:0] n, input logic ena);
    return ena ? (8'b1 << n) : 8'h00;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r);
    m_if.req = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    clrn = 1'b0;
    #1;
    clrn = 1'b1;
  endtask

  task automatic check_grant(input string tag, input logic [2:0] n_exp, input logic ena_exp);
    checkOutput({tag, ".n"}, 32'(m_if.n), 32'(n_exp));
    checkOutput({tag, ".ena"}, 32'(m_if.ena), 32'(ena_exp));
    checkOutput({tag, ".busy"}, 32'(m_if.busy), 32'(ena_exp));
    checkOutput({tag, ".e"}, 32'(decode3e(m_if.n, m_if.ena)), 32'(decode3e(n_exp, ena_exp)));
  endtask

  initial begin
    logic [2:0] slice_seq [9];
    checks = 0;
    errors = 0;
    clrn   = 1'b1;
    applyStimulus(8'hFF);
    f_if.req = 8'h00;

    // Reset takes effect with no clock edge.
    #2;
    clrn = 1'b0;
    #1;
    check_grant("t1_async_reset", 3'd0, 1'b0);
    @(negedge clk);
    clrn = 1'b1;
    step();
    check_grant("t1_first_grant", 3'd0, 1'b1);

    // Zero-bubble handover, then release to idle with n held.
    pulse_reset();
    applyStimulus(8'b1000_0100);
    step();
    check_grant("t2_grant2", 3'd2, 1'b1);
    applyStimulus(8'b1000_0000);
    step();
    check_grant("t2_handover7", 3'd7, 1'b1);
    applyStimulus(8'h00);
    step();
    check_grant("t2_idle", 3'd7, 1'b0);

    // Four-cycle time slices between two requesters.
    pulse_reset();
    applyStimulus(8'h03);
    slice_seq = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    for (int i = 0; i < 9; i++) begin
      step();
      check_grant($sformatf("t3_slice%0d", i), slice_seq[i], 1'b1);
    end

    // Lone requester is never pre-empted; a newcomer gets it once hold expired.
    pulse_reset();
    applyStimulus(8'h20);
    for (int i = 0; i < 10; i++) begin
      step();
      check_grant($sformatf("t4_alone%0d", i), 3'd5, 1'b1);
    end
    applyStimulus(8'h22);
    step();
    check_grant("t4_preempt", 3'd1, 1'b1);

    // Fairness with MAX_HOLD=1 on the second instance.
    pulse_reset();
    applyStimulus(8'h00);
    f_if.req = 8'hFF;
    for (int i = 0; i < 8; i++) idx_count[i] = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      checkOutput($sformatf("t5_n%0d", i), 32'(f_if.n), 32'(i % 8));
      checkOutput($sformatf("t5_ena%0d", i), 32'(f_if.ena), 32'd1);
      if (f_if.ena) idx_count[f_if.n]++;
    end
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("t5_count%0d", i), 32'(idx_count[i]), 32'd8);
    f_if.req = 8'h00;

    // Reset mid-grant drops ena at once and restarts from index 0.
    pulse_reset();
    applyStimulus(8'h40);
    step();
    check_grant("t6_grant6", 3'd6, 1'b1);
    #2;
    clrn = 1'b0;
    #1;
    check_grant("t6_async_drop", 3'd0, 1'b0);
    clrn = 1'b1;
    applyStimulus(8'h41);
    step();
    check_grant("t6_restart", 3'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
